// File: rtl/branch_target_predictor.sv
// BTB with 2-bit saturating direction counters; combinational next-PC prediction for IF,
// trained by resolved EX outcomes. Define BRANCH_STATS_EN to add branch/mispredict counters.
module branch_target_predictor #(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned TAG_BITS = 8,  // must equal 16 - IDX_BITS
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic [15:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [15:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic        upd_cond,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  input  logic        upd_mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
`endif
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [Entries-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [15:0]         target_q [Entries];
  logic [1:0]          ctr_q    [Entries];

  logic [IDX_BITS-1:0] pred_idx, upd_idx;
  logic [TAG_BITS-1:0] pred_tag, upd_tag;

  assign pred_idx = pred_pc[IDX_BITS-1:0];
  assign pred_tag = pred_pc[15:IDX_BITS];
  assign upd_idx  = upd_pc[IDX_BITS-1:0];
  assign upd_tag  = upd_pc[15:IDX_BITS];

  // Gating with Reset_N keeps the outputs clean while the table is still unknown.
  always_comb begin
    pred_hit     = Reset_N && valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
    pred_taken   = pred_hit && ctr_q[pred_idx][1];
    pred_next_pc = pred_taken ? target_q[pred_idx] : pred_pc + 16'd1;
  end

  logic       upd_hit;
  logic       wr_ctr, wr_target, wr_alloc;
  logic [1:0] ctr_d;

  always_comb begin
    upd_hit   = 1'b0;
    wr_ctr    = 1'b0;
    wr_target = 1'b0;
    wr_alloc  = 1'b0;
    ctr_d     = 2'b00;
    if (upd_valid) begin
      upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      if (upd_hit) begin
        wr_ctr = 1'b1;
        if (!upd_cond) begin
          ctr_d     = 2'b11;
          wr_target = 1'b1;
        end else if (upd_taken) begin
          ctr_d     = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          wr_target = 1'b1;
        end else begin
          ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        wr_ctr    = 1'b1;
        wr_target = 1'b1;
        wr_alloc  = 1'b1;
        ctr_d     = upd_cond ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      valid_q <= '0;
      for (int i = 0; i < Entries; i++) ctr_q[i] <= CTR_INIT;
    end else if (wr_ctr) begin
      ctr_q[upd_idx] <= ctr_d;
      if (wr_alloc) valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tags and targets carry no reset; valid qualifies them.
  always_ff @(posedge Clk) begin
    if (Reset_N && wr_target) begin
      target_q[upd_idx] <= upd_target;
      if (wr_alloc) tag_q[upd_idx] <= upd_tag;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (upd_mispredict && stat_mispredicts != 16'hFFFF) begin
        stat_mispredicts <= stat_mispredicts + 16'd1;
      end
    end
  end
`else
  logic unused_mispredict;
  assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios followed by random
// traffic checked against a table model built from the prediction/training rules.
module tb_branch_target_predictor;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic [15:0] pred_pc;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_next_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_cond, upd_taken;
  logic [15:0] upd_target;
  logic        upd_mispredict;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  always #5 Clk = ~Clk;

  branch_target_predictor dut (
    .Clk           (Clk),
    .Reset_N       (Reset_N),
    .pred_pc       (pred_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_next_pc  (pred_next_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_cond      (upd_cond),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference table, indexed by pc mod 256, tagged by pc div 256.
  bit m_valid [256];
  int m_tag   [256];
  int m_tgt   [256];
  int m_ctr   [256];
  int m_br, m_mis;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic model_update(input int pc, input int cond, input int taken, input int tgt,
                              input int mis);
    int idx = pc % 256;
    int tag = pc / 256;
    if (m_br < 65535) m_br++;
    if (mis != 0 && m_mis < 65535) m_mis++;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (cond == 0) begin
        m_ctr[idx] = 3;
        m_tgt[idx] = tgt;
      end else if (taken != 0) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_tgt[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (taken != 0) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_tgt[idx]   = tgt;
      m_ctr[idx]   = (cond != 0) ? 2 : 3;
    end
  endtask

  task automatic upd(input logic [15:0] pc, input logic cond, input logic taken,
                     input logic [15:0] tgt, input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_cond       = cond;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mis;
    tick();
    upd_valid = 1'b0;
    model_update(int'(pc), int'(cond), int'(taken), int'(tgt), int'(mis));
  endtask

  task automatic expect3(input string name, input logic [15:0] pc, input logic h, input logic t,
                         input logic [15:0] nx);
    pred_pc = pc;
    #1;
    chk({name, ".hit"}, {15'd0, pred_hit}, {15'd0, h});
    chk({name, ".taken"}, {15'd0, pred_taken}, {15'd0, t});
    chk({name, ".next"}, pred_next_pc, nx);
  endtask

  task automatic expect_model(input string name, input logic [15:0] pc);
    int  idx = int'(pc) % 256;
    bit  h   = m_valid[idx] && (m_tag[idx] == int'(pc) / 256);
    bit  t   = h && (m_ctr[idx] >= 2);
    logic [15:0] nx;
    nx = t ? 16'(m_tgt[idx]) : 16'((int'(pc) + 1) % 65536);
    expect3(name, pc, h, t, nx);
  endtask

  initial begin
    Reset_N        = 1'b0;
    pred_pc        = 16'h0010;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_cond       = 1'b0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    model_reset();
    tick();
    expect3("in_reset", 16'h0010, 1'b0, 1'b0, 16'h0011);
    Reset_N = 1'b1;
    tick();
    expect3("after_reset", 16'h0010, 1'b0, 1'b0, 16'h0011);

    upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    expect3("alloc_cond", 16'h0010, 1'b1, 1'b1, 16'h0040);
    upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0);
    expect3("nt1_ctr01", 16'h0010, 1'b1, 1'b0, 16'h0011);
    upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0);
    expect3("nt2_ctr00", 16'h0010, 1'b1, 1'b0, 16'h0011);
    upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    expect3("t1_ctr01", 16'h0010, 1'b1, 1'b0, 16'h0011);
    for (int i = 0; i < 4; i++) upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0);
    expect3("sat_then_nt", 16'h0010, 1'b1, 1'b1, 16'h0040);

    upd(16'h0110, 1'b1, 1'b1, 16'h0200, 1'b0);
    expect3("alias_old", 16'h0010, 1'b0, 1'b0, 16'h0011);
    expect3("alias_new", 16'h0110, 1'b1, 1'b1, 16'h0200);

    // Prediction in the update cycle must see pre-update contents.
    upd_valid  = 1'b1;
    upd_pc     = 16'h0020;
    upd_cond   = 1'b1;
    upd_taken  = 1'b1;
    upd_target = 16'h0080;
    expect3("same_cycle_pre", 16'h0020, 1'b0, 1'b0, 16'h0021);
    tick();
    upd_valid = 1'b0;
    model_update(32'h20, 1, 1, 32'h80, 0);
    expect3("same_cycle_post", 16'h0020, 1'b1, 1'b1, 16'h0080);

    expect3("wrap_ffff", 16'hFFFF, 1'b0, 1'b0, 16'h0000);

    upd(16'h0030, 1'b0, 1'b1, 16'h0123, 1'b1);
    upd(16'h0030, 1'b1, 1'b0, 16'h0000, 1'b0);
    expect3("jump_alloc_11", 16'h0030, 1'b1, 1'b1, 16'h0123);
    upd(16'h0060, 1'b1, 1'b0, 16'h0999, 1'b0);
    expect3("miss_nt_noalloc", 16'h0060, 1'b0, 1'b0, 16'h0061);

    upd_pc     = 'x;
    upd_cond   = 'x;
    upd_taken  = 'x;
    upd_target = 'x;
    tick();
    tick();
    expect3("x_idle_hold", 16'h0020, 1'b1, 1'b1, 16'h0080);

    Reset_N    = 1'b0;
    upd_valid  = 1'b1;
    upd_pc     = 16'h0050;
    upd_cond   = 1'b1;
    upd_taken  = 1'b1;
    upd_target = 16'h0077;
    tick();
    upd_valid = 1'b0;
    Reset_N   = 1'b1;
    model_reset();
    tick();
    expect3("reset_beats_upd", 16'h0050, 1'b0, 1'b0, 16'h0051);
    expect3("reset_clears", 16'h0110, 1'b0, 1'b0, 16'h0111);

`ifdef BRANCH_STATS_EN
    upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    upd(16'h0020, 1'b0, 1'b1, 16'h0080, 1'b1);
    upd(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("stat_branches", stat_branches, 16'd3);
    chk("stat_mispredicts", stat_mispredicts, 16'd1);
`endif

    // Random traffic over a small PC pool so hits, aliases and saturation all occur.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ppc, upc;
      logic        v, c, t, m;
      ppc = 16'($urandom_range(0, 2) * 256 + $urandom_range(0, 7));
      upc = 16'($urandom_range(0, 2) * 256 + $urandom_range(0, 7));
      v   = 1'($urandom_range(0, 3) != 0);
      c   = 1'($urandom_range(0, 3) != 0);
      t   = c ? 1'($urandom_range(0, 1)) : 1'b1;
      m   = 1'($urandom_range(0, 1));
      upd_valid      = v;
      upd_pc         = upc;
      upd_cond       = c;
      upd_taken      = t;
      upd_target     = 16'($urandom);
      upd_mispredict = m;
      expect_model($sformatf("rand%0d", n), ppc);
      tick();
      if (v) model_update(int'(upc), int'(c), int'(t), int'(upd_target), int'(m));
      upd_valid = 1'b0;
    end

`ifdef BRANCH_STATS_EN
    chk("rand_stat_branches", stat_branches, 16'(m_br));
    chk("rand_stat_mispredicts", stat_mispredicts, 16'(m_mis));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
